mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter DW, default 32, meaning the data width in bits.
REQ-002 The module SHALL have parameter AW, default 32, meaning the byte-address width in bits.
REQ-003 clk  input  1  Single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  Asynchronous, active-low reset.
REQ-005 req0, req1  input  1 each  Access request from port 0 (CPU load/store) and port 1 (loader/DMA).
REQ-006 we0, we1  input  1 each  Write enable qualifying reqN: 1 = write, 0 = read.
REQ-007 addr0, addr1  input  AW each  Byte address; bits [1:0] are forwarded unchanged and are not checked.
REQ-008 wdata0, wdata1  input  DW each  Write data.
REQ-009 ack0, ack1  output  1 each  One-cycle completion pulse.
REQ-010 rdata0, rdata1  output  DW each  Read data, valid while ackN=1.
REQ-011 mem_we  output  1  Write strobe to the single-port data RAM, which writes on the rising edge.
REQ-012 mem_a  output  AW  RAM address.
REQ-013 mem_wd  output  DW  RAM write data.
REQ-014 mem_rd  input  DW  RAM combinational read data.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-016 IDLE: when any reqN is high at a rising edge, the arbiter SHALL select one port, latch that port's we/addr/wdata and port id, and go to ACCESS.
REQ-017 Simultaneous requests SHALL be resolved round-robin: the port not granted last wins; after reset, port 0 wins.
REQ-018 ACCESS: mem_a, mem_wd and mem_we SHALL be driven only from the latched values, so the RAM write happens at the edge that leaves ACCESS.
REQ-019 At the edge leaving ACCESS, the arbiter SHALL capture mem_rd into the latched port's rdata register and go to RESP.
REQ-020 RESP: ack of the latched port SHALL be 1 for exactly this cycle, and rdata of that port SHALL hold the captured word.
REQ-021 Exit from RESP: if the other port's req is high, the arbiter SHALL latch that port and go directly to ACCESS; otherwise it SHALL go to IDLE.
REQ-022 The port being acked SHALL never be re-granted out of RESP.
REQ-023 Latency SHALL be: req sampled at edge k, mem access during cycle k+1, ack during cycle k+2.
REQ-024 Throughput SHALL be alternating back-to-back grants (one access per 2 cycles) under contention, and 3 cycles per access for a single port.
REQ-025 mem_we SHALL be 0 in every state except ACCESS with the latched we=1.
REQ-026 Each requester SHALL hold reqN and its qualifiers stable until ackN.
REQ-027 Once latched, an access SHALL complete (RAM write, ack) even if reqN drops.
REQ-028 ackN SHALL never be high for both ports in the same cycle.
REQ-029 rdataN SHALL be held between acks, and SHALL be captured for writes as well (RAM contents at addr before the write).

Reset
REQ-030 While rst_n=0, the arbiter SHALL asynchronously force: state=IDLE, ack0=ack1=0, mem_we=0, mem_a=0, mem_wd=0, rdata0=rdata1=0, round-robin pointer to "port 0 first", and statistics counters to 0.
REQ-031 Reset asserted mid-ACCESS SHALL abort the access with no ack; because of the asynchronous clear of mem_we, the RAM write does not occur.
REQ-032 After rst_n deasserts, the first arbitration SHALL occur at the first rising edge that sees rst_n=1.

Configuration
REQ-033 With macro MEM_ARB_STATS_EN defined, the module SHALL add outputs gnt_cnt0 and gnt_cnt1 (16 bits each).
REQ-034 Each gnt_cntN SHALL increment on every grant of port N and saturate at 16'hFFFF.
REQ-035 Without MEM_ARB_STATS_EN, these ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-036 A shared package mem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), the port-id type (1 bit) and the counter width constant (16).
REQ-037 The round-robin selector SHALL be a separate sub-module rr_sel2 (inputs req0, req1, last; output grant id).
REQ-038 The FSM, latches and optional counters SHALL remain in mem_arbiter.

Verification
REQ-039 Single write then read: port 0 writes 32'hDEADBEEF to 0x10, then reads 0x10 -> ack0 in cycle k+2 both times, and rdata0=32'hDEADBEEF on the read ack.
REQ-040 Contention: req0 and req1 both rise in the same cycle after reset -> port 0 acked first, port 1 acked 2 cycles later, and ack0/ack1 are never simultaneous.
REQ-041 Sustained contention over 8 accesses per port -> grants strictly alternate, and with MEM_ARB_STATS_EN gnt_cnt0=gnt_cnt1=8.
REQ-042 Dropped request: port 1 write of 32'h12345678 to 0x20 with req1 dropped in ACCESS -> ack1 still pulses, and a later read of 0x20 returns 32'h12345678.
REQ-043 Reset mid-ACCESS of a write of 32'hA5A5A5A5 to 0x30 (previously 0) -> no ack, mem_we=0 immediately, and a read of 0x30 after reset returns 0.
REQ-044 Saturation: force 65 540 grants on port 0 with MEM_ARB_STATS_EN defined -> gnt_cnt0 holds 16'hFFFF.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: types and constants shared by the memory arbiter files.
//   arb_state_t : arbiter FSM states (IDLE / ACCESS / RESP)
//   port_id_t   : requester identifier (0 = CPU load/store, 1 = loader/DMA)
//   CNT_W       : width of the optional grant statistics counters
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef logic port_id_t;

   localparam port_id_t    PORT0 = 1'b0;
   localparam port_id_t    PORT1 = 1'b1;
   localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/rr_sel2.sv
// rr_sel2: two-way round-robin selector.
// Ports:
//   req0, req1 : request lines of port 0 and port 1
//   last       : id of the port granted most recently
//   gnt        : id of the port to grant (meaningful only when a request is present)
module rr_sel2
   import mem_arb_pkg::*;
(
   input  logic     req0,
   input  logic     req1,
   input  port_id_t last,
   output port_id_t gnt
);

   always_comb begin
      gnt = PORT0;
      if (req0 && req1) begin
         // Tie: the port that did not win last time goes first.
         gnt = ~last;
      end else if (req1) begin
         gnt = PORT1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a single-port data RAM.
// A granted port is latched, its access is presented to the RAM for one cycle
// (ACCESS) and acknowledged in the following cycle (RESP). Out of RESP the other
// port is granted directly if it is requesting, giving alternating back-to-back
// accesses under contention.
// Optional feature: define MEM_ARB_STATS_EN to add saturating grant counters
// gnt_cnt0 / gnt_cnt1.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   reqN, weN           : request and write enable of port N
//   addrN, wdataN       : byte address and write data of port N
//   ackN, rdataN        : one-cycle completion pulse and read data of port N
//   mem_we, mem_a,
//   mem_wd, mem_rd      : RAM write strobe, address, write data, read data
//   gnt_cnt0, gnt_cnt1  : grant counters (MEM_ARB_STATS_EN only)
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic             we0,
   input  logic             we1,
   input  logic [AW-1:0]    addr0,
   input  logic [AW-1:0]    addr1,
   input  logic [DW-1:0]    wdata0,
   input  logic [DW-1:0]    wdata1,
   output logic             ack0,
   output logic             ack1,
   output logic [DW-1:0]    rdata0,
   output logic [DW-1:0]    rdata1,
   output logic             mem_we,
   output logic [AW-1:0]    mem_a,
   output logic [DW-1:0]    mem_wd,
`ifdef MEM_ARB_STATS_EN
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1,
`endif
   input  logic [DW-1:0]    mem_rd
);

   arb_state_t    state_q, state_d;
   port_id_t      lat_id_q;
   port_id_t      last_q;
   port_id_t      rr_gnt;
   port_id_t      gnt_id;
   logic          gnt;
   logic          lat_we_q;
   logic [AW-1:0] lat_addr_q;
   logic [DW-1:0] lat_wdata_q;
   logic [DW-1:0] rdata0_q, rdata1_q;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   rr_sel2 u_rr_sel (
      .req0 (req0),
      .req1 (req1),
      .last (last_q),
      .gnt  (rr_gnt)
   );

   always_comb begin
      state_d = state_q;
      gnt     = 1'b0;
      gnt_id  = rr_gnt;
      unique case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               gnt     = 1'b1;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            state_d = RESP;
         end
         RESP: begin
            // Only the other port may be granted here; the acked port may still
            // show its old request during its ack cycle.
            gnt_id = ~lat_id_q;
            if ((lat_id_q == PORT1) ? req0 : req1) begin
               gnt     = 1'b1;
               state_d = ACCESS;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign sel_we    = (gnt_id == PORT1) ? we1    : we0;
   assign sel_addr  = (gnt_id == PORT1) ? addr1  : addr0;
   assign sel_wdata = (gnt_id == PORT1) ? wdata1 : wdata0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lat_id_q    <= PORT0;
         lat_we_q    <= 1'b0;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
         last_q      <= PORT1;  // pointer at port 1 lets port 0 win the first tie
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         state_q <= state_d;
         if (gnt) begin
            lat_id_q    <= gnt_id;
            lat_we_q    <= sel_we;
            lat_addr_q  <= sel_addr;
            lat_wdata_q <= sel_wdata;
            last_q      <= gnt_id;
         end
         // Captured for writes too: the word the RAM held before the write.
         if (state_q == ACCESS) begin
            if (lat_id_q == PORT1) begin
               rdata1_q <= mem_rd;
            end else begin
               rdata0_q <= mem_rd;
            end
         end
      end
   end

   // RAM side is driven purely from the latch; mem_we depends on state_q so the
   // asynchronous reset kills a write in flight.
   assign mem_we = (state_q == ACCESS) && lat_we_q;
   assign mem_a  = lat_addr_q;
   assign mem_wd = lat_wdata_q;

   assign ack0   = (state_q == RESP) && (lat_id_q == PORT0);
   assign ack1   = (state_q == RESP) && (lat_id_q == PORT1);
   assign rdata0 = rdata0_q;
   assign rdata1 = rdata1_q;

`ifdef MEM_ARB_STATS_EN
   logic [CNT_W-1:0] cnt0_q, cnt1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (gnt && (gnt_id == PORT0) && (cnt0_q != '1)) begin
            cnt0_q <= cnt0_q + CNT_W'(1);
         end
         if (gnt && (gnt_id == PORT1) && (cnt1_q != '1)) begin
            cnt1_q <= cnt1_q + CNT_W'(1);
         end
      end
   end

   assign gnt_cnt0 = cnt0_q;
   assign gnt_cnt1 = cnt1_q;
`else
   // Statistics disabled: no counters, no extra ports.
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a behavioural RAM and
// a shadow-memory reference model. Define MEM_ARB_STATS_EN to also cover the
// grant counters (including saturation).
module tb_mem_arbiter;

   localparam int DW = 32;
   localparam int AW = 32;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          req0   = 1'b0;
   logic          req1   = 1'b0;
   logic          we0    = 1'b0;
   logic          we1    = 1'b0;
   logic [AW-1:0] addr0  = '0;
   logic [AW-1:0] addr1  = '0;
   logic [DW-1:0] wdata0 = '0;
   logic [DW-1:0] wdata1 = '0;
   logic          ack0, ack1;
   logic [DW-1:0] rdata0, rdata1;
   logic          mem_we;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_wd, mem_rd;
`ifdef MEM_ARB_STATS_EN
   logic [15:0]   gnt_cnt0, gnt_cnt1;
`endif

   always #5 clk = ~clk;

   mem_arbiter #(.DW(DW), .AW(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req0     (req0),
      .req1     (req1),
      .we0      (we0),
      .we1      (we1),
      .addr0    (addr0),
      .addr1    (addr1),
      .wdata0   (wdata0),
      .wdata1   (wdata1),
      .ack0     (ack0),
      .ack1     (ack1),
      .rdata0   (rdata0),
      .rdata1   (rdata1),
      .mem_we   (mem_we),
      .mem_a    (mem_a),
      .mem_wd   (mem_wd),
`ifdef MEM_ARB_STATS_EN
      .gnt_cnt0 (gnt_cnt0),
      .gnt_cnt1 (gnt_cnt1),
`endif
      .mem_rd   (mem_rd)
   );

   // Behavioural single-port RAM: write on rising edge, combinational read.
   logic [DW-1:0] ram [64] = '{default: '0};
   always @(posedge clk) if (mem_we) ram[mem_a[7:2]] <= mem_wd;
   assign mem_rd = ram[mem_a[7:2]];

   int checks = 0;
   int errors = 0;
   int exp_cnt0 = 0;
   int exp_cnt1 = 0;
   logic [DW-1:0] shadow [64];

   // Pending transaction per port (random / sustained scenarios).
   logic          p_we   [2];
   logic [AW-1:0] p_addr [2];
   logic [DW-1:0] p_wd   [2];

   task automatic drive_port(input bit port, input bit r, input logic w,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (port) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
      else      begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
   endtask

   task automatic issue_random(input bit port);
      p_we[port]   = 1'($urandom_range(0, 1));
      p_addr[port] = (AW'($urandom_range(0, 63)) << 2) | AW'($urandom_range(0, 3));
      p_wd[port]   = DW'($urandom);
      drive_port(port, 1'b1, p_we[port], p_addr[port], p_wd[port]);
   endtask

   task automatic reset_dut();
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt0 = 0;
      exp_cnt1 = 0;
   endtask

   // One isolated access; lat = ack sample index after the sampling edge, -1 on timeout.
   task automatic do_access(input bit port, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input bit drop_early,
                            output logic [DW-1:0] rd, output int lat);
      @(negedge clk);
      drive_port(port, 1'b1, we, addr, wd);
      lat = -1;
      rd  = '0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (drop_early && c == 1) drive_port(port, 1'b0, we, addr, wd);
         if (port ? ack1 : ack0) begin
            lat = c;
            rd  = port ? rdata1 : rdata0;
            break;
         end
      end
      drive_port(port, 1'b0, we, addr, wd);
      if (lat > 0) begin
         if (we) shadow[addr[7:2]] = wd;
         if (port) exp_cnt1++; else exp_cnt0++;
      end
      @(posedge clk);
   endtask

   task automatic test_reset();
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h44; wdata0 = 32'h1111_2222;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0)
         $display("FAIL reset_ack: ack0=%b ack1=%b expected 0 0", ack0, ack1);
      checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b expected 0", mem_we);
      checks++; if (mem_a !== '0 || mem_wd !== '0)
         $display("FAIL reset_mem_bus: mem_a=%h mem_wd=%h expected 0 0", mem_a, mem_wd);
      checks++; if (rdata0 !== '0 || rdata1 !== '0)
         $display("FAIL reset_rdata: rdata0=%h rdata1=%h expected 0 0", rdata0, rdata1);
`ifdef MEM_ARB_STATS_EN
      checks++; if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0)
         $display("FAIL reset_cnt: cnt0=%0d cnt1=%0d expected 0 0", gnt_cnt0, gnt_cnt1);
`endif
      req0 = 1'b0; we0 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (ack0 !== 1'b0 || mem_we !== 1'b0)
         $display("FAIL idle_after_reset: ack0=%b mem_we=%b expected 0 0", ack0, mem_we);
      errors = errors + ((ack0 !== 1'b0 || mem_we !== 1'b0) ? 1 : 0);
   endtask

   task automatic test_single_write_read();
      logic [DW-1:0] rd, exp;
      int lat;
      exp = shadow[4];
      do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d expected 2", lat); end
      checks++; if (rd !== exp) begin errors++; $display("FAIL wr_old_data: got %h expected %h", rd, exp); end
      do_access(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, rd, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d expected 2", lat); end
      checks++; if (rd !== 32'hDEADBEEF) begin
         errors++; $display("FAIL rd_data: got %h expected deadbeef", rd);
      end
   endtask

   task automatic test_contention();
      int t0 = -1, t1 = -1;
      bit both = 1'b0;
      logic [DW-1:0] r0 = '0, r1 = '0, e0, e1;
      reset_dut();
      e0 = shadow[4];
      e1 = shadow[16];
      @(negedge clk);
      drive_port(1'b0, 1'b1, 1'b0, 32'h10, '0);
      drive_port(1'b1, 1'b1, 1'b0, 32'h40, '0);
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (ack0 && ack1) both = 1'b1;
         if (ack0 && t0 < 0) begin t0 = c; r0 = rdata0; req0 = 1'b0; exp_cnt0++; end
         if (ack1 && t1 < 0) begin t1 = c; r1 = rdata1; req1 = 1'b0; exp_cnt1++; end
      end
      req0 = 1'b0; req1 = 1'b0;
      checks++; if (t0 !== 2) begin errors++; $display("FAIL cont_ack0_cycle: got %0d expected 2", t0); end
      checks++; if (t1 !== 4) begin errors++; $display("FAIL cont_ack1_cycle: got %0d expected 4", t1); end
      checks++; if (both !== 1'b0) begin errors++; $display("FAIL cont_dual_ack: got 1 expected 0"); end
      checks++; if (r0 !== e0) begin errors++; $display("FAIL cont_rdata0: got %h expected %h", r0, e0); end
      checks++; if (r1 !== e1) begin errors++; $display("FAIL cont_rdata1: got %h expected %h", r1, e1); end
   endtask

   task automatic test_dropped_request();
      logic [DW-1:0] rd;
      int lat;
      do_access(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b1, rd, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL drop_ack1: got latency %0d expected 2", lat); end
      do_access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, rd, lat);
      checks++; if (rd !== 32'h12345678) begin
         errors++; $display("FAIL drop_readback: got %h expected 12345678", rd);
      end
   endtask

   task automatic test_reset_mid_access();
      logic [DW-1:0] rd;
      int lat;
      bit seen_ack = 1'b0;
      @(negedge clk);
      drive_port(1'b0, 1'b1, 1'b1, 32'h30, 32'hA5A5A5A5);
      @(posedge clk); #1;
      checks++; if (mem_we !== 1'b1 || mem_wd !== 32'hA5A5A5A5) begin
         errors++; $display("FAIL access_strobe: mem_we=%b mem_wd=%h expected 1 a5a5a5a5", mem_we, mem_wd);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL abort_mem_we: got %b expected 0", mem_we); end
      checks++; if (mem_a !== '0) begin errors++; $display("FAIL abort_mem_a: got %h expected 0", mem_a); end
      req0 = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (ack0 || ack1) seen_ack = 1'b1;
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt0 = 0;
      exp_cnt1 = 0;
      checks++; if (seen_ack !== 1'b0) begin errors++; $display("FAIL abort_no_ack: got 1 expected 0"); end
      do_access(1'b0, 1'b0, 32'h30, 32'h0, 1'b0, rd, lat);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_readback: got %h expected 0", rd); end
   endtask

   task automatic test_random_traffic();
      bit pend [2] = '{1'b0, 1'b0};
      int age [2] = '{0, 0};
      logic [DW-1:0] last_rd [2] = '{'0, '0};
      logic [DW-1:0] exp;
      logic ack [2];
      logic [DW-1:0] rdv [2];
      reset_dut();
      for (int c = 1; c <= 300; c++) begin
         @(posedge clk); #1;
         ack[0] = ack0; ack[1] = ack1;
         rdv[0] = rdata0; rdv[1] = rdata1;
         checks++; if (ack0 && ack1) begin errors++; $display("FAIL rnd_dual_ack: cycle %0d", c); end
         for (int p = 0; p < 2; p++) begin
            if (ack[p]) begin
               checks++;
               if (!pend[p]) begin
                  errors++; $display("FAIL rnd_spurious_ack: port %0d cycle %0d", p, c);
               end else begin
                  exp = shadow[p_addr[p][7:2]];
                  if (rdv[p] !== exp) begin
                     errors++; $display("FAIL rnd_rdata: port %0d got %h expected %h", p, rdv[p], exp);
                  end
                  if (p_we[p]) shadow[p_addr[p][7:2]] = p_wd[p];
                  last_rd[p] = exp;
                  pend[p] = 1'b0;
                  drive_port(p[0], 1'b0, 1'b0, '0, '0);
               end
            end else begin
               checks++; if (rdv[p] !== last_rd[p]) begin
                  errors++; $display("FAIL rnd_hold: port %0d got %h expected %h", p, rdv[p], last_rd[p]);
               end
            end
            if (pend[p]) begin
               age[p]++;
               checks++; if (age[p] > 6) begin
                  errors++; $display("FAIL rnd_timeout: port %0d waited %0d expected <= 6", p, age[p]);
                  pend[p] = 1'b0;
                  drive_port(p[0], 1'b0, 1'b0, '0, '0);
               end
            end
            if (!pend[p] && c < 280 && $urandom_range(0, 1) == 1) begin
               issue_random(p[0]);
               pend[p] = 1'b1;
               age[p] = 0;
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int n [2] = '{0, 0};
      int last_port = -1;
      int last_c = 0;
      logic [DW-1:0] exp;
      logic ack [2];
      logic [DW-1:0] rdv [2];
      reset_dut();
      @(negedge clk);
      issue_random(1'b0);
      issue_random(1'b1);
      for (int c = 1; c <= 60 && !(n[0] == 8 && n[1] == 8); c++) begin
         @(posedge clk); #1;
         ack[0] = ack0; ack[1] = ack1;
         rdv[0] = rdata0; rdv[1] = rdata1;
         checks++; if (ack0 && ack1) begin errors++; $display("FAIL b2b_dual_ack: cycle %0d", c); end
         for (int p = 0; p < 2; p++) begin
            if (ack[p]) begin
               exp = shadow[p_addr[p][7:2]];
               checks++; if (rdv[p] !== exp) begin
                  errors++; $display("FAIL b2b_rdata: port %0d got %h expected %h", p, rdv[p], exp);
               end
               if (p_we[p]) shadow[p_addr[p][7:2]] = p_wd[p];
               checks++; if (p !== ((last_port < 0) ? 0 : 1 - last_port)) begin
                  errors++; $display("FAIL b2b_order: got port %0d after port %0d", p, last_port);
               end
               if (last_port >= 0) begin
                  checks++; if (c - last_c !== 2) begin
                     errors++; $display("FAIL b2b_spacing: got %0d cycles expected 2", c - last_c);
                  end
               end
               last_port = p;
               last_c = c;
               n[p]++;
               if (p == 0) exp_cnt0++; else exp_cnt1++;
               if (n[p] < 8) issue_random(p[0]);
               else drive_port(p[0], 1'b0, 1'b0, '0, '0);
            end
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      checks++; if (n[0] !== 8) begin errors++; $display("FAIL b2b_count0: got %0d expected 8", n[0]); end
      checks++; if (n[1] !== 8) begin errors++; $display("FAIL b2b_count1: got %0d expected 8", n[1]); end
      repeat (2) @(posedge clk);
`ifdef MEM_ARB_STATS_EN
      #1;
      checks++; if (gnt_cnt0 !== 16'd8 || gnt_cnt1 !== 16'd8) begin
         errors++; $display("FAIL b2b_gnt_cnt: cnt0=%0d cnt1=%0d expected 8 8", gnt_cnt0, gnt_cnt1);
      end
`endif
   endtask

`ifdef MEM_ARB_STATS_EN
   task automatic test_saturation();
      int n = 0;
      reset_dut();
      @(negedge clk);
      drive_port(1'b0, 1'b1, 1'b0, 32'h0, '0);
      for (int c = 0; c < 200000 && n < 65540; c++) begin
         @(posedge clk); #1;
         if (ack0) n++;
      end
      req0 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (n !== 65540) begin errors++; $display("FAIL sat_grants: got %0d expected 65540", n); end
      checks++; if (gnt_cnt0 !== 16'hFFFF) begin
         errors++; $display("FAIL sat_cnt0: got %h expected ffff", gnt_cnt0);
      end
      checks++; if (gnt_cnt1 !== 16'h0) begin errors++; $display("FAIL sat_cnt1: got %h expected 0", gnt_cnt1); end
   endtask
`endif

   initial begin
      for (int i = 0; i < 64; i++) shadow[i] = '0;
      test_reset();
      test_single_write_read();
      test_contention();
      test_dropped_request();
      test_reset_mid_access();
      test_random_traffic();
      test_back_to_back();
`ifdef MEM_ARB_STATS_EN
      test_saturation();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
